// File: rtl/bus_write.sv
// bus_write: write side of the shared 16-bit bus. Loads busOut into one
// architectural register per cycle, applies increment/clear micro-ops,
// generates a one-cycle DRAM write strobe and keeps the AC zero flag.
module bus_write #(
  parameter int DW = 16,
  parameter int BW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [4:0]    write_en,
  input  logic [2:0]    inc_en,
  input  logic [2:0]    clr_en,
  input  logic [DW-1:0] busOut,
  output logic [BW-1:0] ir,
  output logic [BW-1:0] tr,
  output logic [BW-1:0] dr,
  output logic [BW-1:0] rn,
  output logic [BW-1:0] rp,
  output logic [BW-1:0] rc,
  output logic [BW-1:0] rr,
  output logic [BW-1:0] rcol1,
  output logic [BW-1:0] rcol2,
  output logic [DW-1:0] ra,
  output logic [DW-1:0] rb,
  output logic [DW-1:0] ro,
  output logic [DW-1:0] rt,
  output logic [DW-1:0] ac,
  output logic [BW-1:0] dram_wdata,
  output logic          dram_we,
  output logic          z
);

  // Destination codes, shared with the read-side bus select
  localparam logic [4:0] WR_IR    = 5'd1;
  localparam logic [4:0] WR_TR    = 5'd2;
  localparam logic [4:0] WR_DR    = 5'd3;
  localparam logic [4:0] WR_RA    = 5'd4;
  localparam logic [4:0] WR_RB    = 5'd5;
  localparam logic [4:0] WR_RO    = 5'd6;
  localparam logic [4:0] WR_RN    = 5'd7;
  localparam logic [4:0] WR_RP    = 5'd8;
  localparam logic [4:0] WR_RC    = 5'd9;
  localparam logic [4:0] WR_RR    = 5'd10;
  localparam logic [4:0] WR_RT    = 5'd11;
  localparam logic [4:0] WR_AC    = 5'd12;
  localparam logic [4:0] WR_DRAM  = 5'd13;
  localparam logic [4:0] WR_ACHI  = 5'd15;
  localparam logic [4:0] WR_RCOL1 = 5'd16;
  localparam logic [4:0] WR_RCOL2 = 5'd17;

  // Increment / clear select codes (7 is reserved and does nothing)
  localparam logic [2:0] SEL_RA = 3'd1;
  localparam logic [2:0] SEL_RB = 3'd2;
  localparam logic [2:0] SEL_RC = 3'd3;
  localparam logic [2:0] SEL_RR = 3'd4;
  localparam logic [2:0] SEL_RT = 3'd5;
  localparam logic [2:0] SEL_RP = 3'd6;

  localparam logic [DW-1:0] ONE_W = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [BW-1:0] ONE_B = {{(BW-1){1'b0}}, 1'b1};

  logic [BW-1:0] r_ir, r_tr, r_dr, r_rn, r_rp, r_rc, r_rr, r_rcol1, r_rcol2;
  logic [DW-1:0] r_ra, r_rb, r_ro, r_rt, r_ac;
  logic [BW-1:0] r_dram_wdata;
  logic          r_dram_we;
  logic          r_z;

  logic [BW-1:0] w_byte;
  logic [DW-1:0] w_ac_hi;

  assign w_byte  = busOut[BW-1:0];
  // Upper-byte load keeps the current low byte of AC
  assign w_ac_hi = {busOut[BW-1:0], r_ac[DW-BW-1:0]};

  // Register file update; later assignments override earlier ones, which
  // gives write > clear > increment when they target the same register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir         <= '0;
      r_tr         <= '0;
      r_dr         <= '0;
      r_rn         <= '0;
      r_rp         <= '0;
      r_rc         <= '0;
      r_rr         <= '0;
      r_rcol1      <= '0;
      r_rcol2      <= '0;
      r_ra         <= '0;
      r_rb         <= '0;
      r_ro         <= '0;
      r_rt         <= '0;
      r_ac         <= '0;
      r_dram_wdata <= '0;
      r_dram_we    <= 1'b0;
      r_z          <= 1'b0;
    end else begin
      r_dram_we <= 1'b0;

      case (inc_en)
        SEL_RA:  r_ra <= r_ra + ONE_W;
        SEL_RB:  r_rb <= r_rb + ONE_W;
        SEL_RC:  r_rc <= r_rc + ONE_B;
        SEL_RR:  r_rr <= r_rr + ONE_B;
        SEL_RT:  r_rt <= r_rt + ONE_W;
        SEL_RP:  r_rp <= r_rp + ONE_B;
        default: ;
      endcase

      case (clr_en)
        SEL_RA:  r_ra <= '0;
        SEL_RB:  r_rb <= '0;
        SEL_RC:  r_rc <= '0;
        SEL_RR:  r_rr <= '0;
        SEL_RT:  r_rt <= '0;
        SEL_RP:  r_rp <= '0;
        default: ;
      endcase

      case (write_en)
        WR_IR:    r_ir    <= w_byte;
        WR_TR:    r_tr    <= w_byte;
        WR_DR:    r_dr    <= w_byte;
        WR_RA:    r_ra    <= busOut;
        WR_RB:    r_rb    <= busOut;
        WR_RO:    r_ro    <= busOut;
        WR_RN:    r_rn    <= w_byte;
        WR_RP:    r_rp    <= w_byte;
        WR_RC:    r_rc    <= w_byte;
        WR_RR:    r_rr    <= w_byte;
        WR_RT:    r_rt    <= busOut;
        WR_AC: begin
          r_ac <= busOut;
          r_z  <= (busOut == '0);
        end
        WR_DRAM: begin
          r_dram_wdata <= w_byte;
          r_dram_we    <= 1'b1;
        end
        WR_ACHI: begin
          r_ac <= w_ac_hi;
          r_z  <= (w_ac_hi == '0);
        end
        WR_RCOL1: r_rcol1 <= w_byte;
        WR_RCOL2: r_rcol2 <= w_byte;
        default:  ;
      endcase
    end
  end

  assign ir         = r_ir;
  assign tr         = r_tr;
  assign dr         = r_dr;
  assign rn         = r_rn;
  assign rp         = r_rp;
  assign rc         = r_rc;
  assign rr         = r_rr;
  assign rcol1      = r_rcol1;
  assign rcol2      = r_rcol2;
  assign ra         = r_ra;
  assign rb         = r_rb;
  assign ro         = r_ro;
  assign rt         = r_rt;
  assign ac         = r_ac;
  assign dram_wdata = r_dram_wdata;
  assign dram_we    = r_dram_we;
  assign z          = r_z;

endmodule

// File: tb/tb_bus_write.sv
// Scoreboard bench for bus_write: stimulus pushes the hand-computed register
// image expected after each edge; a monitor pops and compares every field.
module tb_bus_write;

  typedef struct packed {
    logic [7:0]  ir, tr, dr, rn, rp, rc, rr, rcol1, rcol2;
    logic [15:0] ra, rb, ro, rt, ac;
    logic [7:0]  dram_wdata;
    logic        dram_we;
    logic        z;
  } st_t;

  logic        clk;
  logic        rst_n;
  logic [4:0]  write_en;
  logic [2:0]  inc_en;
  logic [2:0]  clr_en;
  logic [15:0] busOut;
  logic [7:0]  ir, tr, dr, rn, rp, rc, rr, rcol1, rcol2;
  logic [15:0] ra, rb, ro, rt, ac;
  logic [7:0]  dram_wdata;
  logic        dram_we;
  logic        z;

  st_t  exp_s;
  st_t  q[$];
  event mon_ev;
  int   n_cmp = 0;
  int   n_bad = 0;

  bus_write #(.DW(16), .BW(8)) dut (
    .clk(clk), .rst_n(rst_n), .write_en(write_en), .inc_en(inc_en),
    .clr_en(clr_en), .busOut(busOut),
    .ir(ir), .tr(tr), .dr(dr), .rn(rn), .rp(rp), .rc(rc), .rr(rr),
    .rcol1(rcol1), .rcol2(rcol2),
    .ra(ra), .rb(rb), .ro(ro), .rt(rt), .ac(ac),
    .dram_wdata(dram_wdata), .dram_we(dram_we), .z(z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, expv);
    end
  endtask

  // Monitor: compare outputs against the oldest expected image
  initial begin
    st_t e;
    forever begin
      @(negedge clk or mon_ev);
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp("ir", {8'h0, ir}, {8'h0, e.ir});
        cmp("tr", {8'h0, tr}, {8'h0, e.tr});
        cmp("dr", {8'h0, dr}, {8'h0, e.dr});
        cmp("rn", {8'h0, rn}, {8'h0, e.rn});
        cmp("rp", {8'h0, rp}, {8'h0, e.rp});
        cmp("rc", {8'h0, rc}, {8'h0, e.rc});
        cmp("rr", {8'h0, rr}, {8'h0, e.rr});
        cmp("rcol1", {8'h0, rcol1}, {8'h0, e.rcol1});
        cmp("rcol2", {8'h0, rcol2}, {8'h0, e.rcol2});
        cmp("ra", ra, e.ra);
        cmp("rb", rb, e.rb);
        cmp("ro", ro, e.ro);
        cmp("rt", rt, e.rt);
        cmp("ac", ac, e.ac);
        cmp("dram_wdata", {8'h0, dram_wdata}, {8'h0, e.dram_wdata});
        cmp("dram_we", {15'h0, dram_we}, {15'h0, e.dram_we});
        cmp("z", {15'h0, z}, {15'h0, e.z});
      end
    end
  end

  // One clock: drive inputs at the falling edge, queue the expected image at the rising edge
  task automatic cyc(input logic [4:0] we, input logic [2:0] inc, input logic [2:0] clr,
                     input logic [15:0] bus, input logic exp_we);
    write_en = we;
    inc_en   = inc;
    clr_en   = clr;
    busOut   = bus;
    @(posedge clk);
    exp_s.dram_we = exp_we;
    q.push_back(exp_s);
    @(negedge clk);
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; write_en = '0; inc_en = '0; clr_en = '0; busOut = '0;
    exp_s = '0;
    #1;
    q.push_back(exp_s);
    ->mon_ev;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Byte truncation
    exp_s.ir = 8'hAB; cyc(5'd1, 3'd0, 3'd0, 16'h00AB, 1'b0);
    exp_s.ir = 8'h00; cyc(5'd1, 3'd0, 3'd0, 16'h0100, 1'b0);
    exp_s.tr = 8'hFE; cyc(5'd2, 3'd0, 3'd0, 16'hFFFE, 1'b0);

    // AC, upper byte and zero flag
    exp_s.ac = 16'h00FF; exp_s.z = 1'b0; cyc(5'd12, 3'd0, 3'd0, 16'h00FF, 1'b0);
    exp_s.ac = 16'hCEFF;                 cyc(5'd15, 3'd0, 3'd0, 16'h00CE, 1'b0);
    exp_s.ac = 16'h0000; exp_s.z = 1'b1; cyc(5'd12, 3'd0, 3'd0, 16'h0000, 1'b0);
    cyc(5'd0, 3'd0, 3'd0, 16'hFFFF, 1'b0);
    exp_s.ac = 16'h5A00; exp_s.z = 1'b0; cyc(5'd15, 3'd0, 3'd0, 16'h005A, 1'b0);

    // Wrap and priority
    exp_s.rp = 8'hFF;    cyc(5'd8, 3'd0, 3'd0, 16'h00FF, 1'b0);
    exp_s.rp = 8'h00;    cyc(5'd0, 3'd6, 3'd0, 16'h0000, 1'b0);
    exp_s.ra = 16'hFFFF; cyc(5'd4, 3'd0, 3'd0, 16'hFFFF, 1'b0);
    exp_s.ra = 16'h0000; cyc(5'd0, 3'd1, 3'd0, 16'h0000, 1'b0);
    exp_s.rp = 8'h05;    cyc(5'd8, 3'd6, 3'd6, 16'h0005, 1'b0);
    exp_s.rp = 8'h00;    cyc(5'd0, 3'd6, 3'd6, 16'h0000, 1'b0);
    exp_s.ra = 16'h1000; cyc(5'd4, 3'd1, 3'd0, 16'h1000, 1'b0);
    exp_s.ra = 16'h2222; cyc(5'd4, 3'd0, 3'd1, 16'h2222, 1'b0);

    // DRAM strobe
    exp_s.dram_wdata = 8'hFB;
    cyc(5'd13, 3'd0, 3'd0, 16'h01FB, 1'b1);
    cyc(5'd13, 3'd0, 3'd0, 16'h01FB, 1'b1);
    cyc(5'd0,  3'd0, 3'd0, 16'h0000, 1'b0);

    // Concurrent write and increment on different registers
    exp_s.rc = 8'd77;                      cyc(5'd9,  3'd0, 3'd0, 16'd77,  1'b0);
    exp_s.rcol1 = 8'd100; exp_s.rc = 8'd78; cyc(5'd16, 3'd3, 3'd0, 16'd100, 1'b0);

    // Remaining destinations
    exp_s.dr    = 8'h3C;    cyc(5'd3,  3'd0, 3'd0, 16'h123C, 1'b0);
    exp_s.rn    = 8'h71;    cyc(5'd7,  3'd0, 3'd0, 16'h0771, 1'b0);
    exp_s.rr    = 8'hFF;    cyc(5'd10, 3'd0, 3'd0, 16'h00FF, 1'b0);
    exp_s.rcol2 = 8'h99;    cyc(5'd17, 3'd0, 3'd0, 16'hAB99, 1'b0);
    exp_s.rb    = 16'hBEEF; cyc(5'd5,  3'd0, 3'd0, 16'hBEEF, 1'b0);
    exp_s.ro    = 16'hC0DE; cyc(5'd6,  3'd0, 3'd0, 16'hC0DE, 1'b0);
    exp_s.rt    = 16'hFFFF; cyc(5'd11, 3'd0, 3'd0, 16'hFFFF, 1'b0);

    // Increment / clear on the other targets
    exp_s.rr = 8'h00;   cyc(5'd0, 3'd4, 3'd0, 16'h0000, 1'b0);
    exp_s.rt = 16'h0;   cyc(5'd0, 3'd5, 3'd0, 16'h0000, 1'b0);
    exp_s.rt = 16'h1;   cyc(5'd0, 3'd5, 3'd0, 16'h0000, 1'b0);
    exp_s.ro = 16'h1357; exp_s.rb = 16'hBEF0; exp_s.rt = 16'h0;
    cyc(5'd6, 3'd2, 3'd5, 16'h1357, 1'b0);
    cyc(5'd0, 3'd7, 3'd7, 16'hFFFF, 1'b0);
    exp_s.ra = 16'h0;   cyc(5'd0, 3'd0, 3'd1, 16'h0000, 1'b0);
    exp_s.rc = 8'h00;   cyc(5'd0, 3'd0, 3'd3, 16'h0000, 1'b0);
    exp_s.rr = 8'h01;   cyc(5'd0, 3'd4, 3'd0, 16'h0000, 1'b0);
    exp_s.rr = 8'h00;   cyc(5'd0, 3'd0, 3'd4, 16'h0000, 1'b0);
    exp_s.rb = 16'h0;   cyc(5'd0, 3'd0, 3'd2, 16'h0000, 1'b0);

    // No-op codes
    cyc(5'd14, 3'd0, 3'd0, 16'hFFFF, 1'b0);
    cyc(5'd20, 3'd0, 3'd0, 16'hFFFF, 1'b0);
    cyc(5'd31, 3'd0, 3'd0, 16'hFFFF, 1'b0);

    // Asynchronous reset between edges, then AC load on the first edge after release
    write_en = 5'd12; busOut = 16'h1234; inc_en = '0; clr_en = '0;
    #2 rst_n = 1'b0;
    #1 exp_s = '0; q.push_back(exp_s); ->mon_ev;
    #1 rst_n = 1'b1;
    @(posedge clk);
    exp_s.ac = 16'h1234; exp_s.z = 1'b0; q.push_back(exp_s);
    @(negedge clk);

    // Write sampled while reset is low is lost
    write_en = 5'd4; busOut = 16'hAAAA;
    #1 rst_n = 1'b0;
    #1 exp_s = '0; q.push_back(exp_s); ->mon_ev;
    @(posedge clk);
    #1 rst_n = 1'b1; write_en = '0;
    @(negedge clk);
    cyc(5'd0, 3'd0, 3'd0, 16'h0000, 1'b0);

    repeat (2) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: %0d entries left, expected 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_write.md
# bus_write

Write-side counterpart of the processor's shared 16-bit bus. Each cycle it takes the ALU/datapath result on `busOut` and, under a 5-bit `write_en` destination code, loads it into one architectural register. Codes match the read-side bus select code for code. It also handles increment/clear micro-ops on the address and counter registers, generates a one-cycle DRAM write strobe, and maintains the AC zero flag. It owns every register the read-side bus multiplexer sources from, and feeds those registers back to it.

## Interface
Parameters:
- `DW`, 16: bus / wide-register width.
- `BW`, 8: byte-register width; byte destinations take `busOut[BW-1:0]`.

Ports:
- `clk`  in  1  system clock, all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `write_en`  in  5  destination code (see Operation); 0 = no write.
- `inc_en`  in  3  increment select: 0 none, 1 RA, 2 RB, 3 RC, 4 RR, 5 RT, 6 RP, 7 reserved (no-op).
- `clr_en`  in  3  clear select, same encoding as `inc_en`.
- `busOut`  in  DW  write data.
- `ir`, `tr`, `dr`, `rn`, `rp`, `rc`, `rr`, `rcol1`, `rcol2`  out  BW  byte registers.
- `ra`, `rb`, `ro`, `rt`, `ac`  out  DW  wide registers.
- `dram_wdata`  out  BW  DRAM write data.
- `dram_we`  out  1  DRAM write strobe, one cycle.
- `z`  out  1  AC-zero flag.

## Operation
- `write_en` codes:
  - 1 IR, 2 TR, 3 DR, 7 RN, 8 RP, 9 RC, 10 RR, 16 RCOL1, 17 RCOL2: byte load of `busOut[7:0]`; bits above 7 discarded.
  - 4 RA, 5 RB, 6 RO, 11 RT, 12 AC: full 16-bit load.
  - 13: `dram_wdata <= busOut[7:0]`, `dram_we <= 1`.
  - 15: `ac <= {busOut[7:0], ac[7:0]}`. Upper-byte load, low byte preserved.
  - 0, 14, 18–31: no register changes. Code 14 is read-only on the bus (IR−TR).
- Increment: target `<= target + 1`, wrapping modulo 2^width. RP/RC/RR wrap 255→0; RA/RB/RT wrap 65535→0.
- Clear: target `<= 0`.
- Priority when one register is selected by more than one source in the same cycle: write > clear > increment. Lower-priority ops on that register are dropped.
- `write_en`, `inc_en` and `clr_en` naming different registers in the same cycle all take effect together.
- `inc_en` and `clr_en` naming the same register (no write): clear wins.
- `z`:
  - Updated only when AC is written (code 12 or 15): `z <= (new ac == 0)`, evaluated on the post-write value.
  - Holds otherwise.
- `dram_we`:
  - High in the cycle after the code-13 edge; returns to 0 the next cycle unless code 13 is presented again.
  - Back-to-back code 13 keeps it high, with `dram_wdata` updated each cycle.
- Not a state machine beyond the strobe. All outputs are direct register outputs with no combinational path from the inputs.

## Timing
- Latency 1: a value presented with its code before edge N is visible on the output after edge N.
- Inputs are sampled only at rising `clk`. No handshake; the caller holds `write_en` for exactly the cycles it wants written.
- Reset values: every register output, `dram_wdata`, `dram_we` and `z` reset to 0. (AC = 0 at reset, but `z` is still 0 because AC was never written.)
- Reset asserted mid-operation clears everything immediately, independent of `clk`. A write sampled on the edge where `rst_n` is low is lost.
- After `rst_n` deasserts, the first rising edge performs normal updates.

## Test plan
- Reset: drive `write_en`=12, `busOut`=0x1234, pulse `rst_n` low between edges -> all outputs 0 asynchronously. After release, AC = 0x1234 one edge later and `z` = 0.
- Byte truncation: code 1 with `busOut`=256, then code 2 with 0xFFFE -> `ir`=0, `tr`=0xFE. `ra` untouched.
- AC upper byte and flag: code 12 with 0x00FF, then code 15 with 0x00CE -> `ac`=0xCEFF, `z`=0. Then code 12 with 0 -> `z`=1.
- Wrap and priority:
  - RP=255, `inc_en`=6 -> RP=0.
  - RA=0xFFFF, `inc_en`=1 -> RA=0.
  - Same cycle `write_en`=8 (`busOut`=5), `inc_en`=6, `clr_en`=6 -> RP=5.
- DRAM strobe: code 13 with 0x01FB for two consecutive cycles, then 0 -> `dram_we` high exactly two cycles, `dram_wdata`=0xFB, then `dram_we`=0.
- Concurrency and no-ops:
  - Code 16 with 100 plus `inc_en`=3 with RC=77 -> `rcol1`=100, RC=78 same edge.
  - Codes 14 and 20 change nothing.
